// File: rtl/alu_instr_sequencer.sv
// Purpose: multi-cycle decode/read/exec/write-back sequencer sitting in front of a register bank + ALU.
// Latency: handshake accepted in cycle N -> reg_we/done in cycle N+4 -> instr_ready again in cycle N+5.
// Backpressure: instr_ready is high only in IDLE; instr_valid is ignored while an instruction is in flight.
module alu_instr_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rd_addr_a,
  output logic [REG_AW-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [7:0]        alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              reg_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  // Only the fields needed after the handshake are kept; source fields live in rd_addr_a/b.
  logic [5:0]        cls_q;
  logic [REG_AW-1:0] dest_q;
  logic [7:0]        func_q;
  logic              legal;

  // Bits [13:8] carry no meaning for R-type instructions.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[13:8];

  // Legality: class 0 plus one of the eight supported ALU function codes.
  always_comb begin
    legal = 1'b0;
    if (cls_q == 6'b000000) begin
      case (func_q)
        8'h02, 8'h03, 8'h08, 8'h0A, 8'h14, 8'h11, 8'h18, 8'h19: legal = 1'b1;
        default:                                                 legal = 1'b0;
      endcase
    end
  end

  // State register; async reset returns to IDLE so strobes drop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode; strobes are pure functions of state.
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    reg_we      = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) next_state = DECODE;
      end
      DECODE: next_state = legal ? READ : ERROR;
      READ:   next_state = EXEC;
      EXEC:   next_state = WRITE;
      WRITE: begin
        reg_we     = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      ERROR: begin
        err        = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: each stage loads its outputs on leaving its state, and everything holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q       <= '0;
      dest_q      <= '0;
      func_q      <= '0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_func    <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      retired_cnt <= '0;
    end else begin
      if (state == IDLE && instr_valid) begin
        cls_q     <= instr[31:26];
        rd_addr_a <= instr[25:22];
        rd_addr_b <= instr[21:18];
        dest_q    <= instr[17:14];
        func_q    <= instr[7:0];
      end
      // Operands are captured before write-back, so a destination aliasing a source is safe.
      if (state == READ) begin
        alu_a    <= rd_data_a;
        alu_b    <= rd_data_b;
        alu_func <= func_q;
      end
      if (state == EXEC) begin
        wr_data <= alu_result;
        wr_addr <= dest_q;
      end
      if (state == WRITE) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule
